// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller state encoding, block geometry and
// the byte/word transforms used by the round datapaths.
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_BLOCK_W    = 128;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (b^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gf_mul(inv, sq);
      sq = gf_mul(sq, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rn);
    case (rn)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [3:0] rn);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(rn), 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the block is bits [127-8i -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_enc_ctrl_if.sv
// Block-level handshake bundle: plaintext/key in, ciphertext out, busy status.
interface aes_enc_ctrl_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] pt;
  logic [AES_BLOCK_W-1:0] key;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] ct;
  logic                   busy;

  modport master (output in_valid, pt, key, out_ready,
                  input  in_ready, out_valid, ct, busy);
  modport slave  (input  in_valid, pt, key, out_ready,
                  output in_ready, out_valid, ct, busy);
endinterface

// File: rtl/aes_final_round.sv
// Last AES round: same as a full round without MixColumns. Combinational.
module aes_final_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] in,
  input  logic [3:0]             round_num,
  input  logic [AES_BLOCK_W-1:0] keyin,
  output logic [AES_BLOCK_W-1:0] out
);

  logic [AES_BLOCK_W-1:0] round_key;

  assign round_key = key_expand(keyin, round_num);
  assign out       = sub_shift(in) ^ round_key;

endmodule

// File: rtl/round.sv
// One full AES round: next round key, then SubBytes, ShiftRows, MixColumns
// and AddRoundKey with that key. Purely combinational.
module round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] in,
  input  logic [3:0]             round_num,
  input  logic [AES_BLOCK_W-1:0] keyin,
  output logic [AES_BLOCK_W-1:0] out,
  output logic [AES_BLOCK_W-1:0] keyout
);

  assign keyout = key_expand(keyin, round_num);
  assign out    = mix_columns(sub_shift(in)) ^ keyout;

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryptor: one round per clock through a shared round
// datapath, a dedicated final round, and valid/ready on both sides.
module aes_enc_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_enc_ctrl_if.slave  bus
);

  aes_state_e             fsm_q;
  logic [AES_BLOCK_W-1:0] st_q;
  logic [AES_BLOCK_W-1:0] rk_q;
  logic [3:0]             rcnt_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;

  logic [AES_BLOCK_W-1:0] round_st;
  logic [AES_BLOCK_W-1:0] round_key;
  logic [AES_BLOCK_W-1:0] final_st;

  // The round instance also supplies round key 10 while in FINAL.
  round u_round (
    .in        (st_q),
    .round_num (rcnt_q),
    .keyin     (rk_q),
    .out       (round_st),
    .keyout    (round_key)
  );

  aes_final_round u_final (
    .in        (st_q),
    .round_num (rcnt_q),
    .keyin     (rk_q),
    .out       (final_st)
  );

  // NOTE: reset is synchronous, so it lives inside the clocked branch and is
  // only seen on a rising edge; every register, datapath included, is cleared.
  // NOTE: state uses non-blocking assignments so each register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      rcnt_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (bus.in_valid) begin
            st_q       <= bus.pt ^ bus.key;
            rk_q       <= bus.key;
            rcnt_q     <= 4'd1;
            fsm_q      <= ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ROUND: begin
          st_q   <= round_st;
          rk_q   <= round_key;
          rcnt_q <= rcnt_q + 4'd1;
          if (rcnt_q == 4'(NUM_ROUNDS - 1)) fsm_q <= FINAL;
        end
        FINAL: begin
          st_q        <= final_st;
          rk_q        <= round_key;
          fsm_q       <= DONE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.ct        = st_q;

endmodule
